tick_period_meter: RTL
======================

TICK_PERIOD_METER -- requirements
Module: tick_period_meter

Interface
REQ-001 Parameter PERIOD_WIDTH, default 16: width of measured period in clk_i cycles (legal 4..32).
REQ-002 Parameter SYNC_STAGES, default 2: flip-flop stages synchronising pulse_i (legal 1..4).
REQ-003 clk_i  input  1  single block clock; all state updates on its rising edge.
REQ-004 a_rst_n_i  input  1  asynchronous, active-low reset.
REQ-005 enable_i  input  1  measurement enable; 0 = abort and hold idle.
REQ-006 pulse_i  input  1  tick/divided-clock input to be measured; may be asynchronous to clk_i.
REQ-007 m_valid_o  output  1  result available.
REQ-008 m_ready_i  input  1  consumer accepts result when high with m_valid_o.
REQ-009 period_o  output  PERIOD_WIDTH  measured edge-to-edge period in clk_i cycles.
REQ-010 ovf_o  output  1  result is a timeout; period_o all-ones.
REQ-011 overrun_o  output  1  one-cycle pulse: unaccepted result overwritten.

Function
REQ-012 pulse_i passes through a SYNC_STAGES flop chain; rise = last stage high and its one-cycle-delayed copy low.
REQ-013 States: IDLE (waiting for first rise) and MEASURE (counting since last rise).
REQ-014 IDLE: counter held 0; on rise with enable_i=1 -> MEASURE, counter cleared to 0; no result emitted.
REQ-015 MEASURE: counter increments by 1 each cycle without rise.
REQ-016 MEASURE with rise: result period = counter+1 loaded to period_o, ovf_o=0, m_valid_o=1; counter cleared to 0; remain MEASURE.
REQ-017 Rises N clk_i cycles apart yield period_o = N; minimum reportable N = 2 (rise needs a low synchronised sample between).
REQ-018 MEASURE with counter all-ones and no rise: result period_o all-ones, ovf_o=1, m_valid_o=1; -> IDLE.
REQ-019 Counter never wraps; all-ones is reached only via REQ-018.
REQ-020 Result latency: m_valid_o high after the clk_i edge at which the rise condition is true; SYNC_STAGES+1 edges after first edge sampling pulse_i high.
REQ-021 Handshake: result transfers on cycle with m_valid_o and m_ready_i high; m_valid_o clears next edge unless a new result loads the same edge.
REQ-022 period_o and ovf_o stable while m_valid_o=1 and m_ready_i=0, except REQ-023.
REQ-023 New result while m_valid_o=1 and m_ready_i=0: overwrite period_o/ovf_o, m_valid_o stays 1, overrun_o pulses 1 cycle.
REQ-024 New result same cycle as transfer: new result loaded, m_valid_o stays 1, no overrun_o.
REQ-025 enable_i=0: -> IDLE, counter cleared, rise ignored; pending result and handshake unaffected.
REQ-026 enable_i 0->1: measurement restarts at next rise (first interval discarded).

Reset
REQ-027 a_rst_n_i low asynchronously: state IDLE, counter 0, sync chain and edge flop 0, m_valid_o=0, period_o=0, ovf_o=0, overrun_o=0.
REQ-028 Reset assertion mid-measurement or with pending result discards both; after release first rise only arms measurement.
REQ-029 pulse_i high at reset release is not a rise until seen low then high.

Verification
REQ-030 PERIOD_WIDTH=16, pulse_i one-cycle high every 5 cycles, m_ready_i=1 -> first rise no result; each later rise gives period_o=5, ovf_o=0, one m_valid_o cycle.
REQ-031 pulse_i period 2 (alternating) -> period_o=2 continuously; period 1000 -> period_o=1000 (0x03E8).
REQ-032 PERIOD_WIDTH=4, one rise then pulse_i low -> after 15 cycles period_o=0xF, ovf_o=1; next rise emits nothing; following rise 7 later -> period_o=7.
REQ-033 Period 6, m_ready_i=0 two results -> second overwrites, overrun_o one pulse, period_o=6; m_ready_i 1 on a result-load cycle -> no overrun_o, valid stays 1.
REQ-034 enable_i low 3 cycles mid-interval -> no result for that interval; first rise after re-enable discarded, next correct.
REQ-035 a_rst_n_i asserted between clock edges with m_valid_o=1 -> outputs 0 immediately without clock; post-release pulse_i held high gives no result.

Source files
------------

// File: rtl/tick_period_meter_if.sv
// Result channel of the tick period meter: a valid/ready handshake that
// carries the measured period, the timeout flag and the overrun pulse.
interface tick_period_meter_if #(
    parameter int PERIOD_WIDTH = 16
);
    logic                    m_valid_o;
    logic                    m_ready_i;
    logic [PERIOD_WIDTH-1:0] period_o;
    logic                    ovf_o;
    logic                    overrun_o;

    // Producer side (the meter)
    modport master (
        output m_valid_o,
        output period_o,
        output ovf_o,
        output overrun_o,
        input  m_ready_i
    );

    // Consumer side
    modport slave (
        input  m_valid_o,
        input  period_o,
        input  ovf_o,
        input  overrun_o,
        output m_ready_i
    );
endinterface

// File: rtl/tick_period_meter.sv
// Tick period meter: synchronises an (possibly asynchronous) tick input,
// detects its rising edges and reports the number of clk_i cycles between
// consecutive rises. A counter that reaches all-ones without a rise reports
// a timeout. Results are offered on a valid/ready channel; a result that is
// replaced before acceptance raises a one-cycle overrun pulse.
module tick_period_meter #(
    parameter int PERIOD_WIDTH = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                  clk_i,
    input  logic                  a_rst_n_i,
    input  logic                  enable_i,
    input  logic                  pulse_i,
    tick_period_meter_if.master   m_if
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_t;

    localparam logic [PERIOD_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [PERIOD_WIDTH-1:0] CNT_ONES = '1;
    localparam logic [PERIOD_WIDTH-1:0] CNT_ONE  = {{(PERIOD_WIDTH-1){1'b0}}, 1'b1};

    // Input synchroniser and edge detection
    logic [SYNC_STAGES-1:0] sync_r;
    logic [SYNC_STAGES:0]   fill_r;     // bit k set once stage k holds a real sample
    logic                   edge_r;     // one-cycle-delayed copy of the last stage
    logic                   rise_s;

    // Measurement FSM
    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [PERIOD_WIDTH-1:0] cnt_r;
    logic [PERIOD_WIDTH-1:0] cnt_nxt_s;
    logic                    load_s;
    logic [PERIOD_WIDTH-1:0] load_period_s;
    logic                    load_ovf_s;

    // Result registers
    logic                    m_valid_r;
    logic [PERIOD_WIDTH-1:0] period_r;
    logic                    ovf_r;
    logic                    overrun_r;

    // Synchroniser chain, real-sample tracker and edge-history flop
    always_ff @(posedge clk_i or negedge a_rst_n_i) begin
        if (!a_rst_n_i) begin
            sync_r <= '0;
            fill_r <= '0;
            edge_r <= 1'b0;
        end else begin
            sync_r[0] <= pulse_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
            fill_r <= {fill_r[SYNC_STAGES-1:0], 1'b1};
            edge_r <= sync_r[SYNC_STAGES-1];
        end
    end

    // A rise needs edge_r to be a genuine low sample, so a pulse_i held high
    // through reset release is not mistaken for a rising edge.
    assign rise_s = sync_r[SYNC_STAGES-1] & ~edge_r & fill_r[SYNC_STAGES];

    // FSM state and interval counter registers
    always_ff @(posedge clk_i or negedge a_rst_n_i) begin
        if (!a_rst_n_i) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state, counter update and result-load decision
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        load_s        = 1'b0;
        load_period_s = CNT_ZERO;
        load_ovf_s    = 1'b0;
        if (!enable_i) begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = CNT_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cnt_nxt_s = CNT_ZERO;
                    if (rise_s) begin
                        state_nxt_s = ST_MEASURE;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_MEASURE: begin
                    if (cnt_r == CNT_ONES) begin
                        // Period no longer representable: report a timeout.
                        // A coinciding rise restarts the measurement at once.
                        load_s        = 1'b1;
                        load_period_s = CNT_ONES;
                        load_ovf_s    = 1'b1;
                        cnt_nxt_s     = CNT_ZERO;
                        if (rise_s) begin
                            state_nxt_s = ST_MEASURE;
                        end else begin
                            state_nxt_s = ST_IDLE;
                        end
                    end else if (rise_s) begin
                        load_s        = 1'b1;
                        load_period_s = cnt_r + CNT_ONE;
                        load_ovf_s    = 1'b0;
                        cnt_nxt_s     = CNT_ZERO;
                        state_nxt_s   = ST_MEASURE;
                    end else begin
                        cnt_nxt_s   = cnt_r + CNT_ONE;
                        state_nxt_s = ST_MEASURE;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end
            endcase
        end
    end

    // Result holding register with valid/ready handshake and overrun flag
    always_ff @(posedge clk_i or negedge a_rst_n_i) begin
        if (!a_rst_n_i) begin
            m_valid_r <= 1'b0;
            period_r  <= CNT_ZERO;
            ovf_r     <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            if (load_s) begin
                period_r  <= load_period_s;
                ovf_r     <= load_ovf_s;
                m_valid_r <= 1'b1;
                // Overwriting a result the consumer has not taken this cycle
                overrun_r <= m_valid_r & ~m_if.m_ready_i;
            end else begin
                overrun_r <= 1'b0;
                if (m_valid_r && m_if.m_ready_i) begin
                    m_valid_r <= 1'b0;
                end
            end
        end
    end

    assign m_if.m_valid_o = m_valid_r;
    assign m_if.period_o  = period_r;
    assign m_if.ovf_o     = ovf_r;
    assign m_if.overrun_o = overrun_r;

endmodule
